// File: rtl/text_video_gen_if.sv
// Screen-RAM and font-ROM read bus of the text video generator.
// master: the video generator (drives addresses, receives data).
// slave : the memory side (receives addresses, returns data 1 clk later).
interface text_video_gen_if;
   logic [12:0] vram_adr;   // screen RAM read address
   logic [15:0] vram_q;     // {attr[7:0], char[7:0]}, 1-cycle latency
   logic [10:0] font_adr;   // {char[7:0], glyph_row[2:0]}
   logic [7:0]  font_q;     // glyph row, bit 7 = leftmost pixel, 1-cycle latency

   modport master (
      output vram_adr,
      output font_adr,
      input  vram_q,
      input  font_q
   );

   modport slave (
      input  vram_adr,
      input  font_adr,
      output vram_q,
      output font_q
   );
endinterface

// File: rtl/text_video_gen.sv
// Text-mode video generator: 640x480 VGA raster, reads 16-bit screen words
// ({attr, char}) from screen RAM, looks glyph rows up in an 8x8 font ROM and
// drives 12-bit RGB plus syncs through a fixed 3-stage pixel pipeline.
// Optional blinking underline cursor: define VIDEO_CURSOR_EN.
module text_video_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SCR_STRIDE = 128,
   parameter int SCR_WIDTH  = 80,
   parameter int SCR_HEIGHT = 56
) (
   input  logic             clk,
   input  logic             rst_n,
   text_video_gen_if.master mem,
   input  logic [6:0]       cursor_col,
   input  logic [5:0]       cursor_row,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [3:0]       r,
   output logic [3:0]       g,
   output logic [3:0]       b
);

   localparam logic [9:0]  H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]  H_VIS_C  = 10'(H_VISIBLE);
   localparam logic [9:0]  V_VIS_C  = 10'(V_VISIBLE);
   localparam logic [9:0]  H_SS     = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0]  H_SE     = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0]  V_SS     = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0]  V_SE     = 10'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [6:0]  SCR_W_C  = 7'(SCR_WIDTH);
   localparam logic [6:0]  SCR_H_C  = 7'(SCR_HEIGHT);
   localparam logic [12:0] STRIDE_C = 13'(SCR_STRIDE);

   // Palette level for one colour component: base on/off, intensity boost.
   function automatic logic [3:0] level(input logic on, input logic inten);
      if (on)
         return inten ? 4'hF : 4'hA;
      return inten ? 4'h5 : 4'h0;
   endfunction

   // ------------------------------------------------------------------
   // Raster counters
   // ------------------------------------------------------------------
   logic [9:0] hcnt;
   logic [9:0] vcnt;
   logic       h_wrap;
   logic       v_wrap;

   assign h_wrap = (hcnt == H_LAST);
   assign v_wrap = (vcnt == V_LAST);

   // Advance the pixel/line position; vcnt steps when hcnt wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (h_wrap) begin
         hcnt <= '0;
         vcnt <= v_wrap ? '0 : vcnt + 10'd1;
      end else begin
         hcnt <= hcnt + 10'd1;
      end
   end

`ifdef VIDEO_CURSOR_EN
   logic [5:0] frame_cnt;

   // Frame counter; bit 5 gives the 64-frame cursor blink.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         frame_cnt <= '0;
      else if (h_wrap && v_wrap)
         frame_cnt <= frame_cnt + 6'd1;
   end
`else
   logic unused_cursor;
   assign unused_cursor = ^{cursor_col, cursor_row};
`endif

   // ------------------------------------------------------------------
   // Stage 0: decode counters, issue screen RAM read
   // ------------------------------------------------------------------
   logic [6:0]  col;
   logic [6:0]  row;
   logic [12:0] adr0;
   logic        vis0;
   logic        txt0;
   logic        hs0;     // sync asserted (active high internally)
   logic        vs0;

   // Text cell position, screen word address, visibility and sync windows.
   always_comb begin
      col  = hcnt[9:3];
      row  = vcnt[9:3];
      adr0 = {6'd0, row} * STRIDE_C + {6'd0, col};
      vis0 = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
      txt0 = vis0 && (col < SCR_W_C) && (row < SCR_H_C);
      hs0  = (hcnt >= H_SS) && (hcnt < H_SE);
      vs0  = (vcnt >= V_SS) && (vcnt < V_SE);
   end

   assign mem.vram_adr = adr0;

`ifdef VIDEO_CURSOR_EN
   logic cur0;

   // Underline cursor: cell match, glyph rows 6-7, blink phase on.
   always_comb begin
      cur0 = txt0 && (col == cursor_col) && (row == {1'b0, cursor_row}) &&
             (vcnt[2:1] == 2'b11) && frame_cnt[5];
   end
`endif

   // ------------------------------------------------------------------
   // Stage 1: screen word arrives, issue font ROM read
   // ------------------------------------------------------------------
   logic [2:0] px_d1;
   logic [2:0] gr_d1;
   logic       vis_d1;
   logic       txt_d1;
   logic       hs_d1;
   logic       vs_d1;
   logic       live;    // low only while stage 1 still holds reset contents

   // Carry pixel-in-cell, glyph row and flags alongside the RAM read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_d1  <= '0;
         gr_d1  <= '0;
         vis_d1 <= 1'b0;
         txt_d1 <= 1'b0;
         hs_d1  <= 1'b0;
         vs_d1  <= 1'b0;
         live   <= 1'b0;
      end else begin
         px_d1  <= hcnt[2:0];
         gr_d1  <= vcnt[2:0];
         vis_d1 <= vis0;
         txt_d1 <= txt0;
         hs_d1  <= hs0;
         vs_d1  <= vs0;
         live   <= 1'b1;
      end
   end

   // Font address is combinational from the RAM data; held at 0 until the
   // pipeline carries real data so it reads 0 during and just after reset.
   assign mem.font_adr = live ? {mem.vram_q[7:0], gr_d1} : '0;

   // ------------------------------------------------------------------
   // Stage 2: glyph row arrives, select colour
   // ------------------------------------------------------------------
   logic [2:0] px_d2;
   logic [6:0] attr_d2;  // attribute bit 7 is reserved and dropped
   logic       vis_d2;
   logic       txt_d2;
   logic       hs_d2;
   logic       vs_d2;

   // Register attribute with the font read and delay the flags again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_d2   <= '0;
         attr_d2 <= '0;
         vis_d2  <= 1'b0;
         txt_d2  <= 1'b0;
         hs_d2   <= 1'b0;
         vs_d2   <= 1'b0;
      end else begin
         px_d2   <= px_d1;
         attr_d2 <= mem.vram_q[14:8];
         vis_d2  <= vis_d1;
         txt_d2  <= txt_d1;
         hs_d2   <= hs_d1;
         vs_d2   <= vs_d1;
      end
   end

`ifdef VIDEO_CURSOR_EN
   logic cur_d1;
   logic cur_d2;

   // Keep the cursor flag aligned with the pixel it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_d1 <= 1'b0;
         cur_d2 <= 1'b0;
      end else begin
         cur_d1 <= cur0;
         cur_d2 <= cur_d1;
      end
   end
`endif

   logic       pix_bit;
   logic [3:0] fg_idx;
   logic [3:0] bg_idx;
   logic [3:0] col_idx;
   logic [3:0] pal_r;
   logic [3:0] pal_g;
   logic [3:0] pal_b;

   // Pick fg/bg (black outside the text area) and map {I,R,G,B} to RGB444.
   always_comb begin
      pix_bit = mem.font_q[3'd7 - px_d2];
      fg_idx  = attr_d2[3:0];
      bg_idx  = {1'b0, attr_d2[6:4]};
      col_idx = '0;
      if (txt_d2)
         col_idx = pix_bit ? fg_idx : bg_idx;
`ifdef VIDEO_CURSOR_EN
      if (cur_d2)
         col_idx = fg_idx;
`endif
      pal_r = level(col_idx[2], col_idx[3]);
      pal_g = level(col_idx[1], col_idx[3]);
      pal_b = level(col_idx[0], col_idx[3]);
   end

   // ------------------------------------------------------------------
   // Output register: syncs and pixels leave together, 3 clk after stage 0
   // ------------------------------------------------------------------
   // Register pins; colour blanked outside the visible window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         de    <= 1'b0;
         r     <= '0;
         g     <= '0;
         b     <= '0;
      end else begin
         hsync <= ~hs_d2;
         vsync <= ~vs_d2;
         de    <= vis_d2;
         r     <= vis_d2 ? pal_r : '0;
         g     <= vis_d2 ? pal_g : '0;
         b     <= vis_d2 ? pal_b : '0;
      end
   end

endmodule
